// File: rtl/bcd_time_pkg.sv
// Shared types, constants and helpers for the BCD HH:MM:SS timer.
// Packed time layout is {h10,h1,m10,m1,s10,s1}, one nibble each.
package bcd_time_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIG_MAX  = 4'd9;
  localparam bcd_t TENS_MAX = 4'd5;

  localparam int S1_LSB  = 0;
  localparam int S10_LSB = 4;
  localparam int M1_LSB  = 8;
  localparam int M10_LSB = 12;
  localparam int H1_LSB  = 16;
  localparam int H10_LSB = 20;

  function automatic logic bcd_time_valid(
    input logic [23:0] t,
    input int          hmax
  );
    int   hr;
    logic ok;
    hr = int'({28'd0, t[H10_LSB +: 4]}) * 10
       + int'({28'd0, t[H1_LSB +: 4]});
    ok = (t[S1_LSB  +: 4] <= DIG_MAX)
      && (t[S10_LSB +: 4] <= TENS_MAX)
      && (t[M1_LSB  +: 4] <= DIG_MAX)
      && (t[M10_LSB +: 4] <= TENS_MAX)
      && (t[H1_LSB  +: 4] <= DIG_MAX)
      && (t[H10_LSB +: 4] <= DIG_MAX)
      && (hr <= hmax);
    return ok;
  endfunction

endpackage

// File: rtl/bcd_timer_digit.sv
// One BCD digit 0..MAX, up/down with carry/borrow chaining and sync load.
// Carry-out is combinational so a whole chain ripples in one cycle.
module bcd_digit
  import bcd_time_pkg::*;
#(
  parameter bcd_t MAX = DIG_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_dir,
  input  logic i_load,
  input  bcd_t i_d,
  output bcd_t o_q,
  output logic o_co
);

  bcd_t r_q;

  assign o_q  = r_q;
  assign o_co = i_en & (i_dir ? (r_q == 4'd0)
                              : (r_q == MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 4'd0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_en) begin
      if (!i_dir)
        r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
      else
        r_q <= (r_q == 4'd0) ? MAX : r_q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_hms_timer.sv
// BCD HH:MM:SS up/down timer with per-second divider, preset load,
// hour wrap on up-count and saturation at zero on down-count.
module bcd_hms_timer
  import bcd_time_pkg::*;
#(
  parameter int CLK_PER_SEC = 25_000_000,
  parameter int DIV_W       = 25,
  parameter int HOUR_MAX    = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        dir,
  input  logic        load,
  input  logic [23:0] load_val,
  output logic [23:0] disp_num,
  output logic        tick_o,
  output logic        done_o,
  output logic        load_err
);

  localparam logic [DIV_W-1:0] DIV_TC =
    DIV_W'(CLK_PER_SEC - 1);
  localparam logic [7:0] HMAX_BCD =
    {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

  logic [DIV_W-1:0] r_div;
  bcd_t r_h10, r_h1;
  logic r_tick, r_done, r_err;

  bcd_t w_s1, w_s10, w_m1, w_m10;
  logic w_s1_co, w_s10_co, w_m1_co, w_m10_co;
  logic w_valid, w_load_ok, w_sec_evt;
  logic w_zero, w_step, w_last;

  assign w_valid   = bcd_time_valid(load_val, HOUR_MAX);
  assign w_load_ok = load & w_valid;
  assign w_sec_evt = run & (r_div == DIV_TC);
  assign w_zero    = (disp_num == 24'h000000);
  assign w_last    = (disp_num == 24'h000001);
  // Countdown holds at zero: block the digit chain there.
  assign w_step    = w_sec_evt & ~w_load_ok
                   & ~(dir & w_zero);

  assign disp_num = {r_h10, r_h1, w_m10, w_m1,
                     w_s10, w_s1};
  assign tick_o   = r_tick;
  assign done_o   = r_done;
  assign load_err = r_err;

  always_ff @(posedge clk) begin
    if (rst)
      r_div <= '0;
    else if (w_load_ok)
      r_div <= '0;
    else if (run)
      r_div <= (r_div == DIV_TC) ? '0
                                 : r_div + DIV_W'(1);
  end

  bcd_digit #(.MAX(DIG_MAX)) u_s1 (
    .clk(clk), .rst(rst), .i_en(w_step),
    .i_dir(dir), .i_load(w_load_ok),
    .i_d(load_val[S1_LSB +: 4]),
    .o_q(w_s1), .o_co(w_s1_co)
  );

  bcd_digit #(.MAX(TENS_MAX)) u_s10 (
    .clk(clk), .rst(rst), .i_en(w_s1_co),
    .i_dir(dir), .i_load(w_load_ok),
    .i_d(load_val[S10_LSB +: 4]),
    .o_q(w_s10), .o_co(w_s10_co)
  );

  bcd_digit #(.MAX(DIG_MAX)) u_m1 (
    .clk(clk), .rst(rst), .i_en(w_s10_co),
    .i_dir(dir), .i_load(w_load_ok),
    .i_d(load_val[M1_LSB +: 4]),
    .o_q(w_m1), .o_co(w_m1_co)
  );

  bcd_digit #(.MAX(TENS_MAX)) u_m10 (
    .clk(clk), .rst(rst), .i_en(w_m1_co),
    .i_dir(dir), .i_load(w_load_ok),
    .i_d(load_val[M10_LSB +: 4]),
    .o_q(w_m10), .o_co(w_m10_co)
  );

  // Hours wrap at HOUR_MAX as a pair, so they live here, not in bcd_digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h10 <= 4'd0;
      r_h1  <= 4'd0;
    end else if (w_load_ok) begin
      r_h10 <= load_val[H10_LSB +: 4];
      r_h1  <= load_val[H1_LSB +: 4];
    end else if (w_m10_co) begin
      if (!dir) begin
        if ({r_h10, r_h1} == HMAX_BCD) begin
          r_h10 <= 4'd0;
          r_h1  <= 4'd0;
        end else if (r_h1 == DIG_MAX) begin
          r_h10 <= r_h10 + 4'd1;
          r_h1  <= 4'd0;
        end else begin
          r_h1  <= r_h1 + 4'd1;
        end
      end else begin
        if (r_h1 != 4'd0) begin
          r_h1  <= r_h1 - 4'd1;
        end else if (r_h10 != 4'd0) begin
          r_h10 <= r_h10 - 4'd1;
          r_h1  <= DIG_MAX;
        end else begin
          r_h10 <= HMAX_BCD[7:4];
          r_h1  <= HMAX_BCD[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_tick <= w_sec_evt & ~w_load_ok;
      r_done <= w_step & dir & w_last;
      r_err  <= load & ~w_valid;
    end
  end

endmodule

// File: tb/tb_bcd_hms_timer.sv
// Self-checking bench for bcd_hms_timer: directed tables and sequences,
// then random stimulus against a seconds-count reference model.
module tb_bcd_hms_timer;

  localparam int CPS  = 4;
  localparam int HMAX = 23;
  localparam int DAY  = (HMAX + 1) * 3600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        dir = 1'b0;
  logic        load = 1'b0;
  logic [23:0] load_val = 24'h0;
  logic [23:0] disp_num;
  logic        tick_o, done_o, load_err;

  bcd_hms_timer #(
    .CLK_PER_SEC(CPS), .DIV_W(2), .HOUR_MAX(HMAX)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .dir(dir),
    .load(load), .load_val(load_val),
    .disp_num(disp_num), .tick_o(tick_o),
    .done_o(done_o), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int m_div = 0;
  int m_secs = 0;
  bit m_tick = 0, m_done = 0, m_err = 0;

  typedef struct {
    logic [23:0] val;
    logic        err;
    logic [23:0] disp;
  } ld_vec_t;

  ld_vec_t lv[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic int dig(input logic [23:0] v,
                             input int k);
    return int'((v >> (4 * k)) & 24'hF);
  endfunction

  function automatic bit m_valid(input logic [23:0] v);
    return dig(v,0) <= 9 && dig(v,1) <= 5
        && dig(v,2) <= 9 && dig(v,3) <= 5
        && dig(v,4) <= 9 && dig(v,5) <= 9
        && dig(v,5) * 10 + dig(v,4) <= HMAX;
  endfunction

  function automatic int to_secs(input logic [23:0] v);
    return (dig(v,5) * 10 + dig(v,4)) * 3600
         + (dig(v,3) * 10 + dig(v,2)) * 60
         + dig(v,1) * 10 + dig(v,0);
  endfunction

  function automatic logic [23:0] pack(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10),
            4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic model_step();
    bit ok, evt;
    if (rst) begin
      m_div = 0; m_secs = 0;
      m_tick = 0; m_done = 0; m_err = 0;
    end else begin
      ok  = load && m_valid(load_val);
      evt = run && m_div == CPS - 1;
      m_tick = 0; m_done = 0;
      m_err = load && !ok;
      if (ok) begin
        m_secs = to_secs(load_val);
        m_div = 0;
      end else begin
        if (run) m_div = (m_div == CPS - 1) ? 0 : m_div + 1;
        if (evt) begin
          m_tick = 1;
          if (!dir) m_secs = (m_secs + 1) % DAY;
          else if (m_secs > 0) begin
            m_secs--;
            m_done = (m_secs == 0);
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_load(input logic [23:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic wait_tick(input string nm,
                           input int exp_n);
    int n;
    n = 0;
    do begin
      cyc(); n++;
    end while (!tick_o && n < 16);
    chk({nm, "_lat"}, n, exp_n);
  endtask

  initial begin
    lv[0] = '{24'h006000, 1'b1, 24'h120000};
    lv[1] = '{24'h240000, 1'b1, 24'h120000};
    lv[2] = '{24'h1A0000, 1'b1, 24'h120000};
    lv[3] = '{24'h00000A, 1'b1, 24'h120000};
    lv[4] = '{24'h000070, 1'b1, 24'h120000};
    lv[5] = '{24'h235959, 1'b0, 24'h235959};
    lv[6] = '{24'h990000, 1'b1, 24'h235959};
    lv[7] = '{24'h230000, 1'b0, 24'h230000};
    lv[8] = '{24'h000000, 1'b0, 24'h000000};

    // reset, then first ticks from 00:00:00
    cyc(); cyc();
    chk("rst_disp", disp_num, 24'h0);
    chk("rst_flags", {tick_o, done_o, load_err}, 3'b000);
    rst = 1'b0; run = 1'b1; dir = 1'b0;
    wait_tick("first", 4);
    chk("first_disp", disp_num, 24'h000001);
    repeat (36) cyc();
    chk("t40_disp", disp_num, 24'h000010);

    // hour wrap
    do_load(24'h235959);
    wait_tick("wrap", 4);
    chk("wrap_disp", disp_num, 24'h000000);
    chk("wrap_done", done_o, 1'b0);

    // countdown borrow, done, saturation
    dir = 1'b1;
    do_load(24'h010000);
    wait_tick("borrow", 4);
    chk("borrow_disp", disp_num, 24'h005959);
    do_load(24'h000001);
    wait_tick("zero", 4);
    chk("zero_disp", disp_num, 24'h000000);
    chk("zero_done", done_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_tick("sat", 4);
      chk("sat_disp", disp_num, 24'h000000);
      chk("sat_done", done_o, 1'b0);
    end

    // load validation table
    run = 1'b0;
    do_load(24'h120000);
    chk("pre_disp", disp_num, 24'h120000);
    for (int i = 0; i < 9; i++) begin
      do_load(lv[i].val);
      chk("ld_err", load_err, lv[i].err);
      chk("ld_disp", disp_num, lv[i].disp);
      cyc();
      chk("ld_err_pulse", load_err, 1'b0);
    end

    // pause preserves the sub-second phase
    dir = 1'b0; run = 1'b1;
    cyc(); cyc();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("pause_tick", tick_o, 1'b0);
    end
    run = 1'b1;
    wait_tick("pause", 2);
    chk("pause_disp", disp_num, 24'h000001);

    // direction change mid-second
    cyc();
    dir = 1'b1;
    wait_tick("dirchg", 3);
    chk("dirchg_disp", disp_num, 24'h000000);
    chk("dirchg_done", done_o, 1'b1);

    // load coincident with terminal count
    dir = 1'b0;
    repeat (3) cyc();
    do_load(24'h000500);
    chk("coin_disp", disp_num, 24'h000500);
    chk("coin_tick", tick_o, 1'b0);
    wait_tick("coin", 4);
    chk("coin_next", disp_num, 24'h000501);

    // invalid load on terminal: tick still happens
    repeat (3) cyc();
    do_load(24'h006000);
    chk("bad_coin", {tick_o, load_err}, 2'b11);
    chk("bad_disp", disp_num, 24'h000502);

    // run dropped on terminal cycle holds the divider
    repeat (3) cyc();
    run = 1'b0;
    repeat (5) cyc();
    run = 1'b1;
    wait_tick("hold", 1);

    // reset mid-count
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("mrst_out",
        {disp_num, tick_o, done_o, load_err}, 27'h0);
    rst = 1'b0;
    wait_tick("mrst", 4);
    chk("mrst_disp", disp_num, 24'h000001);

    // random stimulus against the model
    for (int i = 0; i < 2500; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      run  = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      load = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 0)
        load_val = 24'($urandom);
      else if ($urandom_range(0, 1) == 0)
        load_val = pack($urandom_range(DAY - 8, DAY - 1));
      else
        load_val = pack($urandom_range(0, 70));
      cyc();
      chk("rnd_disp", disp_num, pack(m_secs));
      chk("rnd_flags", {tick_o, done_o, load_err},
          {m_tick, m_done, m_err});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_hms_timer.md
Name: bcd_hms_timer

Overview:
Parametrised BCD time counter, HH:MM:SS, with a built-in per-second divider.
- Counts up as a clock/stopwatch or down as a countdown timer.
- Supports run/pause, preset load with BCD validation, and a configurable hour wrap.
- Drives the seven-segment display path in place of the fixed MM:SS up-counter.

Parameters:
CLK_PER_SEC, 25_000_000, clk cycles per second; divider terminal count is CLK_PER_SEC-1
DIV_W, 25, divider width; must hold CLK_PER_SEC-1
HOUR_MAX, 23, highest hour value, decimal 1..99; up-count wraps after it

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
run  in  1  level; 1 = divider advances, 0 = pause
dir  in  1  0 = count up, 1 = count down
load  in  1  single-cycle load request
load_val  in  24  BCD preset {h10,h1,m10,m1,s10,s1}
disp_num  out  24  current time, same packing as load_val
tick_o  out  1  one-cycle pulse, coincident with each count update
done_o  out  1  one-cycle pulse when a down-count reaches 00:00:00
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on clk edge with rst=1, divider=0, disp_num=0, tick_o=0, done_o=0, load_err=0. rst has priority over all other inputs.
- Divider:
  - Increments only when run=1.
  - Holds its value while run=0; pause preserves the sub-second phase.
  - At CLK_PER_SEC-1 with run=1, it wraps to 0 and generates an internal sec_evt.
- Count update on sec_evt; all outputs registered; new disp_num is visible on the cycle after the terminal edge, with tick_o=1 in that same cycle.
- Up (dir=0):
  - s1 0-9 carries into s10 0-5, which carries into m1 0-9, then m10 0-5, then hours.
  - Hours count 00..HOUR_MAX in BCD.
  - HOUR_MAX:59:59 -> 00:00:00, tick_o=1, done_o=0.
- Down (dir=1):
  - Borrow chain mirrors up mode; s1 0 -> 9 with borrow, s10 0 -> 5, and so on.
  - Example: 01:00:00 -> 00:59:59.
  - 00:00:01 -> 00:00:00 with tick_o=1 and done_o=1 in the same cycle.
  - At 00:00:00, further sec_evt leave the count unchanged, with tick_o=1 and done_o=0. The countdown saturates and never wraps.
- Load (priority over sec_evt in the same cycle):
  - load_val is valid if every digit <=9, s10<=5, m10<=5, and hours <= HOUR_MAX.
  - Valid: disp_num=load_val next cycle and divider=0. No tick_o/done_o that cycle, even if a terminal count coincided.
  - Invalid: load_err=1 for one cycle. disp_num and divider are unchanged, and a coincident sec_evt is processed normally.
  - Load works with run=0 or run=1.
- dir may change at any time and takes effect on the next sec_evt; the divider is not disturbed.
- run falling on the terminal cycle means no sec_evt; the divider holds at CLK_PER_SEC-1.
- Reset mid-second discards the divider phase; counting restarts from 0.
- tick_o, done_o and load_err are never high for more than one consecutive cycle per event.

Decomposition:
- Shared package bcd_time_pkg:
  - 4-bit BCD digit type.
  - Digit limit constants DIG_MAX=9 and TENS_MAX=5.
  - Field offsets within the 24-bit packed time.
  - Function validating a packed BCD time against a given hour limit.
- One sub-module, bcd_digit: a single BCD digit with MAX parameter, up/down, carry/borrow in and out, and synchronous load. It is instantiated for s1, s10, m1 and m10.
- Hours wrap/saturate logic and divider stay in the top level.

Test Plan:
(all with CLK_PER_SEC=4, HOUR_MAX=23)
1. rst=1 for 2 cycles, then run=1, dir=0 -> disp_num=0x000000; first tick_o 4 cycles after run, with disp_num=0x000001; after 40 run cycles disp_num=0x000010.
2. load 0x235959, dir=0, run=1 -> next tick: disp_num=0x000000, tick_o=1, done_o=0.
3. Down mode:
   - load 0x010000, dir=1 -> next tick 0x005959.
   - load 0x000001 -> next tick 0x000000 with done_o=1.
   - Two further ticks keep 0x000000 with done_o=0.
4. Invalid loads:
   - With disp_num=0x120000, load 0x006000 -> load_err=1, disp_num stays 0x120000.
   - Load 0x240000 -> load_err=1.
   - Load 0x1A0000 -> load_err=1.
5. Pause and direction:
   - run=1 for 2 cycles, run=0 for 10, run=1 -> tick_o after exactly 2 more run cycles.
   - Toggle dir mid-second -> divider phase unaffected.
6. Coincident and interrupting events:
   - load 0x000500 asserted on a terminal cycle -> disp_num=0x000500, no tick_o, next tick 4 cycles later.
   - rst asserted mid-count -> all outputs 0 on the next cycle.
